// File: rtl/rice_pkg.sv
// Shared constants for the Rice decompression path.
// Window, encoder and assembler stages all size themselves from these.
package rice_pkg;

    localparam int IN_W  = 32;
    localparam int WIN_W = 64;
    localparam int BUF_W = IN_W + WIN_W;
    localparam int CNT_W = 7;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rice_funnel_shift.sv
// Combinational left shift of the bit buffer with an optional word
// inserted directly behind the surviving bits.
module rice_funnel_shift #(
    parameter int IN_W  = rice_pkg::IN_W,
    parameter int BUF_W = rice_pkg::BUF_W,
    parameter int CNT_W = rice_pkg::CNT_W
) (
    input  logic [BUF_W-1:0] i_buf,
    input  logic [CNT_W-1:0] i_shift,
    input  logic             i_ins,
    input  logic [IN_W-1:0]  i_word,
    input  logic [CNT_W-1:0] i_pos,
    output logic [BUF_W-1:0] o_buf
);

    logic [BUF_W-1:0] w_word_ext;
    logic [BUF_W-1:0] w_shifted;
    logic [BUF_W-1:0] w_inserted;

    assign w_word_ext = {i_word, {(BUF_W-IN_W){1'b0}}};
    assign w_shifted  = i_buf << i_shift;
    assign w_inserted = i_ins ? (w_word_ext >> i_pos) : '0;
    assign o_buf      = w_shifted | w_inserted;

endmodule

// File: rtl/rice_bit_window.sv
// MSB-aligned bit buffer feeding the Rice priority encoder: accepts
// 32-bit words, presents a 64-bit window and discards consumed bits.
module rice_bit_window #(
    parameter int IN_W  = rice_pkg::IN_W,
    parameter int WIN_W = rice_pkg::WIN_W,
    parameter int BUF_W = rice_pkg::BUF_W,
    parameter int CNT_W = rice_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_avail,
    input  logic             cons_en,
    input  logic [CNT_W-1:0] cons_len,
    output logic             cons_err,
    output logic             stream_done
);

    localparam logic [CNT_W-1:0] LP_WIN = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] LP_IN  = CNT_W'(IN_W);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_fill;
    logic             r_eos;
    logic             r_err;

    logic [CNT_W-1:0] w_avail;
    logic             w_win_valid;
    logic             w_ready;
    logic             w_legal;
    logic             w_bad;
    logic             w_acc;
    logic [CNT_W-1:0] w_c;
    logic [CNT_W-1:0] w_pos;
    logic [CNT_W-1:0] w_fill_nxt;
    logic [BUF_W-1:0] w_buf_nxt;

    assign w_avail     = (r_fill >= LP_WIN) ? LP_WIN : r_fill;
    assign w_win_valid = (r_fill >= LP_WIN) || (r_eos && r_fill != '0);
    assign w_ready     = !r_eos && (r_fill <= LP_WIN);

    // Zero-length requests are silently ignored, never flagged.
    assign w_legal = cons_en && w_win_valid && (cons_len != '0)
                     && (cons_len <= w_avail);
    assign w_bad   = cons_en && (cons_len != '0) && !w_legal;
    assign w_c     = w_legal ? cons_len : '0;
    assign w_acc   = in_valid && w_ready;
    assign w_pos   = r_fill - w_c;

    assign w_fill_nxt = r_fill - w_c + (w_acc ? LP_IN : '0);

    rice_funnel_shift #(
        .IN_W  (IN_W),
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_funnel (
        .i_buf   (r_buf),
        .i_shift (w_c),
        .i_ins   (w_acc),
        .i_word  (in_data),
        .i_pos   (w_pos),
        .o_buf   (w_buf_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf  <= '0;
            r_fill <= '0;
            r_eos  <= 1'b0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_buf  <= '0;
            r_fill <= '0;
            r_eos  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_fill <= w_fill_nxt;
            if (w_acc && in_last) r_eos <= 1'b1;
            if (w_bad)            r_err <= 1'b1;
        end
    end

    assign in_ready    = w_ready;
    assign win         = r_buf[BUF_W-1 -: WIN_W];
    assign win_valid   = w_win_valid;
    assign win_avail   = w_avail;
    assign cons_err    = r_err;
    assign stream_done = r_eos && (r_fill == '0);

endmodule

// File: tb/tb_rice_bit_window.sv
// Directed plus random checks of rice_bit_window against a bit-queue
// model of the unconsumed stream.
module tb_rice_bit_window;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] win;
    logic        win_valid;
    logic [6:0]  win_avail;
    logic        cons_en;
    logic [6:0]  cons_len;
    logic        cons_err;
    logic        stream_done;

    int n_assert = 0;
    int n_fail   = 0;

    bit mq[$];
    bit m_eos;
    bit m_err;

    logic [31:0] w0, w1, w2;
    logic [63:0] exp_w;

    rice_bit_window dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .win         (win),
        .win_valid   (win_valid),
        .win_avail   (win_avail),
        .cons_en     (cons_en),
        .cons_len    (cons_len),
        .cons_err    (cons_err),
        .stream_done (stream_done)
    );

    always #5 clk = ~clk;

    function automatic int m_avail();
        return (mq.size() > 64) ? 64 : mq.size();
    endfunction

    function automatic bit m_wv();
        return (mq.size() >= 64) || (m_eos && mq.size() != 0);
    endfunction

    function automatic bit m_rdy();
        return !m_eos && (mq.size() <= 64);
    endfunction

    function automatic logic [63:0] m_win();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < mq.size()) r[63-i] = mq[i];
        return r;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_eos = 0;
        m_err = 0;
    endtask

    task automatic m_cycle(input logic iv, input logic il,
                           input logic [31:0] d, input logic ce,
                           input logic [6:0] cl, input logic fl);
        bit legal;
        bit acc;
        if (fl) begin
            m_clear();
            return;
        end
        legal = ce && m_wv() && cl >= 1 && int'(cl) <= m_avail();
        acc   = iv && m_rdy();
        if (ce && cl != 0 && !legal) m_err = 1;
        if (legal) repeat (int'(cl)) void'(mq.pop_front());
        if (acc) begin
            for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
            if (il) m_eos = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".win"}, win, m_win());
        chk({tag, ".win_valid"}, 64'(win_valid), 64'(m_wv()));
        chk({tag, ".win_avail"}, 64'(win_avail), 64'(m_avail()));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_rdy()));
        chk({tag, ".cons_err"}, 64'(cons_err), 64'(m_err));
        chk({tag, ".done"}, 64'(stream_done),
            64'(m_eos && mq.size() == 0));
    endtask

    task automatic step(input string tag, input logic iv,
                        input logic il, input logic [31:0] d,
                        input logic ce, input logic [6:0] cl,
                        input logic fl);
        in_valid = iv;
        in_last  = il;
        in_data  = d;
        cons_en  = ce;
        cons_len = cl;
        flush    = fl;
        m_cycle(iv, il, d, ce, cl, fl);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last  = 0;
        in_data  = '0;
        cons_en  = 0;
        cons_len = '0;
        flush    = 0;
        check_all(tag);
    endtask

    initial begin
        reset    = 1;
        flush    = 0;
        in_valid = 1;
        in_last  = 1;
        in_data  = 32'hDEADBEEF;
        cons_en  = 0;
        cons_len = '0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        reset    = 0;
        in_valid = 0;
        in_last  = 0;
        #1;
        check_all("rst_rel");

        step("fill1", 1, 0, 32'hF0000000, 0, 0, 0);
        chk("cold_not_valid", 64'(win_valid), 64'd0);
        step("fill2", 1, 0, 32'h0000000F, 0, 0, 0);
        chk("fill_win", win, 64'hF00000000000000F);
        chk("fill_avail", 64'(win_avail), 64'd64);
        step("fill3", 1, 0, 32'hAAAAAAAA, 0, 0, 0);
        chk("full_ready", 64'(in_ready), 64'd0);

        step("cons4", 0, 0, '0, 1, 7'd4, 0);
        chk("cons4_win", win, 64'h00000000000000FA);
        step("cons57", 0, 0, '0, 1, 7'd57, 0);
        chk("cons57_avail", 64'(win_avail), 64'd35);
        chk("cons57_ready", 64'(in_ready), 64'd1);

        w0 = $urandom;
        w1 = $urandom;
        w2 = $urandom;
        step("sim_flush", 0, 0, '0, 0, 0, 1);
        step("sim_w0", 1, 0, w0, 0, 0, 0);
        step("sim_w1", 1, 0, w1, 0, 0, 0);
        step("sim", 1, 0, w2, 1, 7'd10, 0);
        exp_w = ({w0, w1} << 10) | {32'd0, w2 >> 22};
        chk("sim_win", win, exp_w);
        chk("sim_ready", 64'(in_ready), 64'd0);

        step("ill_flush", 0, 0, '0, 0, 0, 1);
        step("ill_w0", 1, 0, w1, 0, 0, 0);
        step("ill_w1", 1, 0, w2, 0, 0, 0);
        step("ill", 0, 0, '0, 1, 7'd65, 0);
        chk("ill_err", 64'(cons_err), 64'd1);
        chk("ill_win", win, {w1, w2});
        step("ill_zero", 0, 0, '0, 1, 7'd0, 0);
        step("ill_sticky", 0, 0, '0, 0, 0, 0);
        chk("ill_sticky_err", 64'(cons_err), 64'd1);
        step("ill_clr", 0, 0, '0, 0, 0, 1);
        chk("ill_clr_err", 64'(cons_err), 64'd0);

        step("drain_push", 1, 1, 32'h80000000, 0, 0, 0);
        chk("drain_avail", 64'(win_avail), 64'd32);
        chk("drain_ready", 64'(in_ready), 64'd0);
        step("drain_blocked", 1, 0, 32'h12345678, 0, 0, 0);
        step("drain_cons", 0, 0, '0, 1, 7'd32, 0);
        chk("drain_done", 64'(stream_done), 64'd1);

        step("rd_flush", 0, 0, '0, 0, 0, 1);
        step("rd_push", 1, 1, $urandom, 0, 0, 0);
        step("rd_cons", 0, 0, '0, 1, 7'd8, 0);
        #2;
        reset = 1;
        m_clear();
        #1;
        check_all("rst_async");
        in_valid = 1;
        in_data  = $urandom;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset    = 0;
        in_valid = 0;
        #1;
        check_all("rst_done");

        for (int k = 0; k < 800; k++) begin
            logic        iv, il, ce, fl;
            logic [6:0]  cl;
            logic [31:0] d;
            iv = 1'($urandom % 2);
            il = ($urandom % 40) == 0;
            d  = $urandom;
            ce = ($urandom % 4) != 0;
            cl = 7'($urandom_range(0, m_avail() + 3));
            fl = (($urandom % 150) == 0)
                 || (m_eos && mq.size() == 0 && ($urandom % 4) == 0);
            step("rand", iv, il, d, ce, cl, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
